// File: rtl/cordic_atan_seq.sv
// +----------------------------------------------------------------------------+
// | cordic_atan_seq                                                            |
// | Streams atan(2^-i) angle constants, i = 0..n-1, over valid/ready for a     |
// | folded CORDIC core. Optional macro CORDIC_ATAN_ROUND_EN selects            |
// | round-half-up instead of truncation when narrowing below 32 bits.          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module cordic_atan_seq #(
  parameter int ANGLE_W = 32,
  parameter int ITER    = 16,
  parameter int IDX_W   = 5
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [IDX_W-1:0]   cfg_iter_i,
  input  logic               abort_i,
  input  logic               ready_i,
  output logic               valid_o,
  output logic [ANGLE_W-1:0] angle_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               last_o,
  output logic               busy_o,
  output logic               done_o
);

  localparam int               c_DEPTH = 2 ** IDX_W;
  localparam logic [IDX_W-1:0] c_ITER  = IDX_W'(ITER);

  // floor(atan(2^-i) / 2pi * 2^32)
  function automatic logic [31:0] e32(input int i);
    case (i)
      0:  return 32'h2000_0000;  1:  return 32'h12E4_051D;
      2:  return 32'h09FB_385B;  3:  return 32'h0511_11D4;
      4:  return 32'h028B_0D43;  5:  return 32'h0145_D7E1;
      6:  return 32'h00A2_F61E;  7:  return 32'h0051_7C55;
      8:  return 32'h0028_BE53;  9:  return 32'h0014_5F2E;
      10: return 32'h000A_2F98;  11: return 32'h0005_17CC;
      12: return 32'h0002_8BE6;  13: return 32'h0001_45F3;
      14: return 32'h0000_A2F9;  15: return 32'h0000_517C;
      16: return 32'h0000_28BE;  17: return 32'h0000_145F;
      18: return 32'h0000_0A2F;  19: return 32'h0000_0517;
      20: return 32'h0000_028B;  21: return 32'h0000_0145;
      22: return 32'h0000_00A2;  23: return 32'h0000_0051;
      24: return 32'h0000_0028;  25: return 32'h0000_0014;
      26: return 32'h0000_000A;  27: return 32'h0000_0005;
      28: return 32'h0000_0002;  29: return 32'h0000_0001;
      default: return 32'h0000_0000;
    endcase
  endfunction

  function automatic logic [ANGLE_W-1:0] angle_of(input int i);
    logic [32:0] v;
    v = {1'b0, e32(i)};
`ifdef CORDIC_ATAN_ROUND_EN
    if (ANGLE_W < 32) v = v + (33'd1 << ((ANGLE_W < 32) ? (31 - ANGLE_W) : 0));
`endif
    v = v >> (32 - ANGLE_W);
    return v[ANGLE_W-1:0];
  endfunction

  // Constant table padded to the full index space so any idx is a legal lookup.
  logic [ANGLE_W-1:0] w_table [c_DEPTH];
  for (genvar g = 0; g < c_DEPTH; g++) begin : g_table
    assign w_table[g] = (g < ITER) ? angle_of(g) : '0;
  end

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t             r_state;
  logic [IDX_W-1:0]   r_n;
  logic [IDX_W-1:0]   r_idx;
  logic [ANGLE_W-1:0] r_angle;
  logic               r_valid;
  logic               r_last;
  logic               r_done;

  logic [IDX_W-1:0] w_n;
  logic [IDX_W-1:0] w_idx_nxt;

  assign w_n       = (cfg_iter_i > c_ITER) ? c_ITER : cfg_iter_i;
  assign w_idx_nxt = r_idx + 1'b1;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_n     <= '0;
      r_idx   <= '0;
      r_angle <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start_i && !abort_i && (w_n != '0)) begin
            r_state <= S_RUN;
            r_n     <= w_n;
            r_idx   <= '0;
            r_angle <= w_table[0];
            r_valid <= 1'b1;
            r_last  <= (w_n == IDX_W'(1));
          end
        end
        S_RUN: begin
          // Abort outranks a handshake in the same cycle.
          if (abort_i || (ready_i && r_last)) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_angle <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_done  <= !abort_i;
          end else if (ready_i) begin
            r_idx   <= w_idx_nxt;
            r_angle <= w_table[w_idx_nxt];
            r_last  <= (w_idx_nxt == (r_n - 1'b1));
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign valid_o = r_valid;
  assign angle_o = r_angle;
  assign idx_o   = r_idx;
  assign last_o  = r_last;
  assign busy_o  = (r_state == S_RUN);
  assign done_o  = r_done;

endmodule

`default_nettype wire

// File: tb/tb_cordic_atan_seq.sv
// +----------------------------------------------------------------------------+
// | tb_cordic_atan_seq                                                         |
// | Directed bench for cordic_atan_seq at 32-bit and 16-bit angle widths.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_cordic_atan_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [4:0]  cfg;
  logic        abort;
  logic        ready;

  logic        valid32, last32, busy32, done32;
  logic [31:0] angle32;
  logic [4:0]  idx32;
  logic        valid16, last16, busy16, done16;
  logic [15:0] angle16;
  logic [4:0]  idx16;

  int checks   = 0;
  int failures = 0;

  logic [31:0] e32 [0:15] = '{
    32'h2000_0000, 32'h12E4_051D, 32'h09FB_385B, 32'h0511_11D4,
    32'h028B_0D43, 32'h0145_D7E1, 32'h00A2_F61E, 32'h0051_7C55,
    32'h0028_BE53, 32'h0014_5F2E, 32'h000A_2F98, 32'h0005_17CC,
    32'h0002_8BE6, 32'h0001_45F3, 32'h0000_A2F9, 32'h0000_517C};

`ifdef CORDIC_ATAN_ROUND_EN
  logic [15:0] e16 [0:6] = '{16'h2000, 16'h12E4, 16'h09FB, 16'h0511,
                             16'h028B, 16'h0146, 16'h00A3};
`else
  logic [15:0] e16 [0:6] = '{16'h2000, 16'h12E4, 16'h09FB, 16'h0511,
                             16'h028B, 16'h0145, 16'h00A2};
`endif

  cordic_atan_seq #(.ANGLE_W(32), .ITER(16), .IDX_W(5)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .cfg_iter_i(cfg),
    .abort_i(abort), .ready_i(ready), .valid_o(valid32), .angle_o(angle32),
    .idx_o(idx32), .last_o(last32), .busy_o(busy32), .done_o(done32));

  cordic_atan_seq #(.ANGLE_W(16), .ITER(16), .IDX_W(5)) dut16 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .cfg_iter_i(cfg),
    .abort_i(abort), .ready_i(ready), .valid_o(valid16), .angle_o(angle16),
    .idx_o(idx16), .last_o(last16), .busy_o(busy16), .done_o(done16));

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic launch(input logic [4:0] n);
    @(negedge clk);
    cfg   = n;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; cfg = '0; abort = 1'b0; ready = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({valid32, last32, busy32, done32, idx32, angle32} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got v=%b l=%b b=%b d=%b idx=%0d ang=%h, need all 0",
               valid32, last32, busy32, done32, idx32, angle32);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic;
    ready = 1'b1;
    launch(5'd4);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (!(valid32 === 1'b1 && idx32 === 5'(k) && angle32 === e32[k] &&
            last32 === (k == 3) && busy32 === 1'b1 && done32 === 1'b0)) begin
        failures++;
        $display("FAIL basic_beat%0d: got v=%b idx=%0d ang=%h last=%b busy=%b, need v=1 idx=%0d ang=%h last=%b busy=1",
                 k, valid32, idx32, angle32, last32, busy32, k, e32[k], (k == 3));
      end
      @(negedge clk);
    end
    checks++;
    if (!(done32 === 1'b1 && valid32 === 1'b0 && busy32 === 1'b0)) begin
      failures++;
      $display("FAIL basic_done: got done=%b v=%b busy=%b, need done=1 v=0 busy=0",
               done32, valid32, busy32);
    end
    @(negedge clk);
    checks++;
    if (done32 !== 1'b0) begin
      failures++;
      $display("FAIL basic_done_pulse: got done=%b one cycle later, need 0", done32);
    end
  endtask

  task automatic test_width16;
    ready = 1'b1;
    launch(5'd7);
    for (int k = 0; k < 7; k++) begin
      checks++;
      if (!(valid16 === 1'b1 && idx16 === 5'(k) && angle16 === e16[k])) begin
        failures++;
        $display("FAIL w16_beat%0d: got v=%b idx=%0d ang=%h, need v=1 idx=%0d ang=%h",
                 k, valid16, idx16, angle16, k, e16[k]);
      end
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    int exp_idx;
    int cyc;
    bit seen_done;
    logic [31:0] held;
    exp_idx = 0; cyc = 0; seen_done = 0; held = '0;
    ready = 1'b1;
    launch(5'd5);
    while (!seen_done && cyc < 40) begin
      if (done32) begin
        seen_done = 1;
      end else begin
        checks++;
        if (!(valid32 === 1'b1 && idx32 === 5'(exp_idx) && angle32 === e32[exp_idx] &&
              last32 === (exp_idx == 4))) begin
          failures++;
          $display("FAIL bp_cycle%0d: got v=%b idx=%0d ang=%h last=%b, need v=1 idx=%0d ang=%h last=%b",
                   cyc, valid32, idx32, angle32, last32, exp_idx, e32[exp_idx], (exp_idx == 4));
        end
        ready = (cyc % 3 == 0);
        if (ready) exp_idx++;
      end
      cyc++;
      @(negedge clk);
    end
    ready = 1'b1;
    checks++;
    if (!(seen_done && exp_idx == 5)) begin
      failures++;
      $display("FAIL bp_count: got beats=%0d done=%0d, need beats=5 done=1", exp_idx, seen_done);
    end
  endtask

  task automatic test_zero;
    int v_cnt;
    int d_cnt;
    v_cnt = 0; d_cnt = 0;
    ready = 1'b1;
    launch(5'd0);
    for (int k = 0; k < 5; k++) begin
      if (valid32) v_cnt++;
      if (done32) d_cnt++;
      @(negedge clk);
    end
    checks++;
    if (v_cnt != 0 || d_cnt != 0 || busy32 !== 1'b0) begin
      failures++;
      $display("FAIL zero_iter: got valid_cycles=%0d done_cycles=%0d busy=%b, need 0 0 0",
               v_cnt, d_cnt, busy32);
    end
  endtask

  task automatic test_clamp;
    int beats;
    int cyc;
    logic [4:0]  last_idx;
    logic [31:0] last_ang;
    beats = 0; cyc = 0; last_idx = '0; last_ang = '0;
    ready = 1'b1;
    launch(5'd31);
    while (!done32 && cyc < 40) begin
      if (valid32) begin
        beats++;
        last_idx = idx32;
        last_ang = angle32;
      end
      cyc++;
      @(negedge clk);
    end
    checks++;
    if (!(done32 === 1'b1 && beats == 16 && last_idx == 5'd15 && last_ang == e32[15])) begin
      failures++;
      $display("FAIL clamp: got beats=%0d last_idx=%0d ang=%h done=%b, need 16 15 %h 1",
               beats, last_idx, last_ang, done32, e32[15]);
    end
    @(negedge clk);
  endtask

  task automatic test_single;
    ready = 1'b1;
    launch(5'd1);
    checks++;
    if (!(valid32 === 1'b1 && idx32 === 5'd0 && last32 === 1'b1 && angle32 === e32[0])) begin
      failures++;
      $display("FAIL single_beat: got v=%b idx=%0d last=%b ang=%h, need 1 0 1 %h",
               valid32, idx32, last32, angle32, e32[0]);
    end
    @(negedge clk);
    checks++;
    if (!(done32 === 1'b1 && valid32 === 1'b0)) begin
      failures++;
      $display("FAIL single_done: got done=%b v=%b, need done=1 v=0", done32, valid32);
    end
    @(negedge clk);
  endtask

  task automatic test_abort;
    int d_cnt;
    int cyc;
    d_cnt = 0; cyc = 0;
    ready = 1'b1;
    launch(5'd8);
    while (idx32 != 5'd2 && cyc < 10) begin
      cyc++;
      @(negedge clk);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if (!(valid32 === 1'b0 && idx32 === 5'd0 && done32 === 1'b0 && busy32 === 1'b0)) begin
      failures++;
      $display("FAIL abort_run: got v=%b idx=%0d done=%b busy=%b, need 0 0 0 0",
               valid32, idx32, done32, busy32);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (done32) d_cnt++;
    end
    checks++;
    if (d_cnt != 0) begin
      failures++;
      $display("FAIL abort_nodone: got done_cycles=%0d, need 0", d_cnt);
    end
    // Abort together with start in IDLE must keep the block idle.
    cfg = 5'd3; start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    checks++;
    if (!(valid32 === 1'b0 && busy32 === 1'b0)) begin
      failures++;
      $display("FAIL abort_idle: got v=%b busy=%b, need 0 0", valid32, busy32);
    end
    launch(5'd3);
    checks++;
    if (!(valid32 === 1'b1 && idx32 === 5'd0 && angle32 === e32[0])) begin
      failures++;
      $display("FAIL abort_restart: got v=%b idx=%0d ang=%h, need 1 0 %h",
               valid32, idx32, angle32, e32[0]);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (done32 !== 1'b1) begin
      failures++;
      $display("FAIL abort_restart_done: got done=%b, need 1", done32);
    end
    @(negedge clk);
  endtask

  task automatic test_async_reset;
    ready = 1'b1;
    launch(5'd6);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({valid32, last32, busy32, done32, idx32, angle32} !== '0) begin
      failures++;
      $display("FAIL async_reset: got v=%b l=%b b=%b d=%b idx=%0d ang=%h, need all 0",
               valid32, last32, busy32, done32, idx32, angle32);
    end
    @(negedge clk);
    rst = 1'b0;
    launch(5'd2);
    checks++;
    if (!(valid32 === 1'b1 && idx32 === 5'd0 && angle32 === e32[0] && last32 === 1'b0)) begin
      failures++;
      $display("FAIL async_restart: got v=%b idx=%0d ang=%h last=%b, need 1 0 %h 0",
               valid32, idx32, angle32, last32, e32[0]);
    end
    @(negedge clk);
    checks++;
    if (!(idx32 === 5'd1 && angle32 === e32[1] && last32 === 1'b1)) begin
      failures++;
      $display("FAIL async_restart_b1: got idx=%0d ang=%h last=%b, need 1 %h 1",
               idx32, angle32, last32, e32[1]);
    end
    @(negedge clk);
    checks++;
    if (done32 !== 1'b1) begin
      failures++;
      $display("FAIL async_restart_done: got done=%b, need 1", done32);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_width16();
    test_backpressure();
    test_zero();
    test_clamp();
    test_single();
    test_abort();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
